hv_adc_conv_sched: RTL

//  HV-side scheduler for the two on-die ADC channels feeding adc_data1/adc_data2.

---
 rtl/hv_adc_conv_sched_pkg.sv | 7 +
 rtl/hv_adc_conv_sched_if.sv | 21 ++
 rtl/hv_adc_conv_sched_avg4.sv | 24 ++
 rtl/hv_adc_conv_sched.sv | 106 ++++++++++
 4 files changed

// File: rtl/hv_adc_conv_sched_pkg.sv
// hv_adc_conv_sched_pkg: shared states, channel indices and defaults for the HV ADC scheduler
package hv_adc_pkg;
  typedef enum logic [2:0] {IDLE, DVRST, START, WAIT, GAP} adc_st_e;
  localparam int CH1 = 0;
  localparam int CH2 = 1;
  localparam int TO_CYC_DEF = 255;
endpackage

// File: rtl/hv_adc_conv_sched_if.sv
// hv_adc_conv_sched_if: scheduler-facing ADC/config bundle; master = scheduler, slave = environment
interface hv_adc_conv_sched_if #(parameter int DW = 10);
  logic [1:0]    adc_en;
  logic [7:0]    period;
  logic          adc_ready1, adc_ready2;
  logic [DW-1:0] adc_data1, adc_data2;
  logic          err_clr;
  logic          dvm_rst;
  logic [1:0]    adc_start;
  logic [DW-1:0] ch1_data, ch2_data;
  logic [1:0]    ch_vld, timeout_err;
  logic          busy;
  modport master (
    input  adc_en, period, adc_ready1, adc_ready2, adc_data1, adc_data2, err_clr,
    output dvm_rst, adc_start, ch1_data, ch2_data, ch_vld, timeout_err, busy
  );
  modport slave (
    output adc_en, period, adc_ready1, adc_ready2, adc_data1, adc_data2, err_clr,
    input  dvm_rst, adc_start, ch1_data, ch2_data, ch_vld, timeout_err, busy
  );
endinterface

// File: rtl/hv_adc_conv_sched_avg4.sv
// hv_adc_avg4: 4-deep sample history; avg includes the incoming sample so it can be registered on push
module hv_adc_avg4 #(parameter int DW = 10) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] avg
);
  logic [DW-1:0] h0, h1, h2;
  logic [DW+1:0] sum;
  assign sum = (DW+2)'(din) + (DW+2)'(h0) + (DW+2)'(h1) + (DW+2)'(h2);
  assign avg = sum[DW+1:2];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {h2, h1, h0} <= '0;
    end else if (clr) begin
      h0 <= push ? din : '0;
      {h2, h1} <= '0;
    end else if (push) begin
      {h2, h1, h0} <= {h1, h0, din};
    end
  end
endmodule

// File: rtl/hv_adc_conv_sched.sv
// hv_adc_conv_sched: round-robin DVM reset / conversion trigger scheduler for two ADC channels.
// Define HV_ADC_AVG_EN to publish a 4-sample running average instead of the raw sample.
module hv_adc_conv_sched
  import hv_adc_pkg::*;
#(
  parameter int DW       = 10,
  parameter int TO_CYC   = TO_CYC_DEF,
  parameter int SYNC_STG = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  hv_adc_conv_sched_if.master bus
);
  localparam int CW = $clog2(TO_CYC + 1);
  adc_st_e st;
  logic sel, nxt, cap, cap_ch, pick, done_sel, p1, p2;
  logic [SYNC_STG-1:0] s1, s2;
  logic [DW-1:0] samp, res1, res2;
  logic [CW-1:0] cnt;
  logic [7:0] gap_cnt, gap_ld;
  assign pick     = bus.adc_en[nxt] ? nxt : ~nxt;
  assign done_sel = sel ? (s2[SYNC_STG-1] & ~p2) : (s1[SYNC_STG-1] & ~p1);
  assign gap_ld   = bus.period == 8'd0 ? 8'd1 : bus.period;
  assign bus.busy = st != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {s1, s2, p1, p2} <= '0;
    end else begin
      s1 <= {s1[SYNC_STG-2:0], bus.adc_ready1};
      s2 <= {s2[SYNC_STG-2:0], bus.adc_ready2};
      p1 <= s1[SYNC_STG-1];
      p2 <= s2[SYNC_STG-1];
    end
  end
`ifdef HV_ADC_AVG_EN
  logic [1:0] en_q;
  always_ff @(posedge i_clk or negedge i_rst_n) en_q <= !i_rst_n ? 2'b00 : bus.adc_en;
  hv_adc_avg4 #(.DW(DW)) u_avg1 (.i_clk, .i_rst_n, .push(cap && !cap_ch), .clr(en_q[0] && !bus.adc_en[0]), .din(samp), .avg(res1));
  hv_adc_avg4 #(.DW(DW)) u_avg2 (.i_clk, .i_rst_n, .push(cap && cap_ch), .clr(en_q[1] && !bus.adc_en[1]), .din(samp), .avg(res2));
`else
  assign res1 = samp;
  assign res2 = samp;
`endif
  // Result is latched on the done edge, then published with its strobe one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st              <= IDLE;
      sel             <= 1'(CH1);
      nxt             <= 1'(CH1);
      cap             <= 1'b0;
      cap_ch          <= 1'b0;
      samp            <= '0;
      cnt             <= '0;
      gap_cnt         <= '0;
      bus.dvm_rst     <= 1'b0;
      bus.adc_start   <= '0;
      bus.ch1_data    <= '0;
      bus.ch2_data    <= '0;
      bus.ch_vld      <= '0;
      bus.timeout_err <= '0;
    end else begin
      cap             <= 1'b0;
      bus.ch_vld      <= '0;
      bus.timeout_err <= bus.timeout_err & ~{2{bus.err_clr}};
      if (cap) begin
        bus.ch_vld[cap_ch] <= 1'b1;
        if (cap_ch) bus.ch2_data <= res2;
        else bus.ch1_data <= res1;
      end
      case (st)
        IDLE: if (|bus.adc_en) begin
          sel         <= pick;
          nxt         <= ~pick;
          bus.dvm_rst <= 1'b1;
          st          <= DVRST;
        end
        DVRST: begin
          bus.dvm_rst        <= 1'b0;
          bus.adc_start[sel] <= 1'b1;
          st                 <= START;
        end
        START: begin
          bus.adc_start <= '0;
          cnt           <= '0;
          st            <= WAIT;
        end
        WAIT: if (done_sel) begin
          samp    <= sel ? bus.adc_data2 : bus.adc_data1;
          cap     <= 1'b1;
          cap_ch  <= sel;
          gap_cnt <= gap_ld;
          st      <= GAP;
        end else if (cnt == CW'(TO_CYC)) begin
          bus.timeout_err[sel] <= 1'b1;
          gap_cnt              <= gap_ld;
          st                   <= GAP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        GAP: if (gap_cnt <= 8'd1) st <= IDLE;
             else gap_cnt <= gap_cnt - 8'd1;
        default: st <= IDLE;
      endcase
    end
  end
endmodule
